// File: rtl/bin_display_ctrl.sv
// bin_display_ctrl: 7-bit binary to 3-digit BCD converter (iterative double dabble)
// driving a time-multiplexed, optionally leading-zero-blanked 7-segment display.
`default_nettype none

module bin_display_ctrl #(
    parameter int SCAN_DIV      = 4,
    parameter int BLANK_LEADING = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  bin,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    typedef enum logic [0:0] {IDLE, CONV} state_t;

    state_t      state_q;
    logic [6:0]  shift_q;
    logic [11:0] scratch_q;
    logic [2:0]  iter_q;
    logic        busy_q;
    logic        done_q;
    logic [11:0] bcd_q;
    logic [15:0] div_q;
    logic [1:0]  idx_q;

    logic [11:0] adj;
    logic [11:0] scratch_d;
    logic [6:0]  shift_d;

    // One double-dabble iteration: add-3 on nibbles >= 5, then shift {scratch, shift} left.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < 3; i++) begin
            if (scratch_q[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
            end
        end
        scratch_d = (adj << 1) | {11'd0, shift_q[6]};
        shift_d   = shift_q << 1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            iter_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        shift_q   <= bin;
                        scratch_q <= '0;
                        iter_q    <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= CONV;
                    end
                end
                CONV: begin
                    shift_q   <= shift_d;
                    scratch_q <= scratch_d;
                    iter_q    <= iter_q + 3'd1;
                    if (iter_q == 3'd6) begin
                        bcd_q   <= scratch_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Free-running scan; deliberately independent of the conversion FSM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
            idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end else begin
            div_q <= div_q + 16'd1;
        end
    end

    logic [3:0] nib;
    logic       blank;

    always_comb begin
        an    = 3'b100;
        nib   = bcd_q[11:8];
        blank = (BLANK_LEADING != 0) && (bcd_q[11:8] == 4'd0);
        case (idx_q)
            2'd0: begin
                an    = 3'b001;
                nib   = bcd_q[3:0];
                blank = 1'b0;
            end
            2'd1: begin
                an    = 3'b010;
                nib   = bcd_q[7:4];
                blank = (BLANK_LEADING != 0) && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
            end
            default: ;
        endcase

        case (nib)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b0011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1110011;
            default: seg = 7'b0000000;
        endcase
        if (blank) begin
            seg = 7'b0000000;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

`default_nettype wire

// File: doc/bin_display_ctrl.md
Name: bin_display_ctrl

Overview:
- Sequential controller for the 3-digit binary-to-decimal 7-segment display path.
- Accepts a 7-bit binary value (0..127) through a load/busy handshake and converts it to BCD with an iterative shift-add-3 (double dabble) FSM.
- Holds the result in a display register and time-multiplexes the three digits onto one shared segment bus with one-hot digit enables.
- Optionally blanks leading zeros.

Parameters:
- SCAN_DIV, 4: clock cycles each digit stays enabled; legal range 1..65535.
- BLANK_LEADING, 1: 1 = blank leading-zero hundreds/tens digits; 0 = always show all three digits.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- bin  in  7  binary value to display; sampled only on an accepted load.
- load  in  1  conversion request; accepted when load=1 and busy=0 at a rising edge.
- busy  out  1  conversion in progress; load is ignored while high.
- done  out  1  one-cycle pulse when a new BCD value has been committed.
- bcd  out  12  committed BCD value: [11:8] hundreds, [7:4] tens, [3:0] ones.
- seg  out  7  segments a..g in bit6..bit0, active high.
- an  out  3  one-hot digit enable, active high: 001 ones, 010 tens, 100 hundreds.

Behaviour:
- Reset values (asynchronous, immediate):
  - busy=0, done=0, bcd=12'h000.
  - Scan index=0, divider=0, so an=001 and seg=1111110.
  - FSM returns to IDLE.
  - A reset during CONV abandons the conversion and leaves bcd unchanged from its reset value (0).
- FSM states: IDLE, CONV.
- IDLE, edge with load=1:
  - shift register <= bin; scratch BCD <= 0; iteration count <= 0; busy <= 1; next state CONV.
- CONV, each edge (one iteration):
  - Each scratch nibble >=5 gets +3.
  - Then {scratch, shift} shifts left by 1.
  - Iteration count increments.
- CONV, 7th iteration edge:
  - bcd <= final scratch value; busy <= 0; done <= 1; next state IDLE.
- done clears on the following edge.
- Latency: load accepted at edge E0; iterations at E1..E7; bcd, done and busy updated at E7. busy is high for exactly 7 cycles.
- Back-to-back loads: a load present while done=1 is accepted at that edge (busy=0).
- Load while busy=1 is dropped, not queued; bin changes during CONV have no effect.
- Scratch width is 12 bits; the hundreds nibble never exceeds 1 for a 7-bit input. No overflow case exists.
- Scan timing:
  - The divider counts 0..SCAN_DIV-1 continuously, independent of the FSM.
  - When divider=SCAN_DIV-1, it wraps to 0 and the scan index advances 0->1->2->0.
  - With SCAN_DIV=1, the index advances every cycle.
- Display source: scan always reads the committed bcd register, so the old value stays displayed during CONV. A new value appears from the cycle after E7 on whichever digit is currently enabled. The scan phase is not reset by load.
- an and seg are combinational decodes of the registered scan index and bcd; both change in the same cycle.
- Digit patterns (a..g):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=0011111, 7=1110000, 8=1111111, 9=1110011
  - blank=0000000
- Blanking (BLANK_LEADING=1):
  - Hundreds is blank when hundreds=0.
  - Tens is blank when hundreds=0 and tens=0.
  - Ones is never blanked.
  - an is still asserted for blanked digits.
- Nibbles >9 cannot occur; if forced, seg=0000000.

Test Plan:
- Reset asserted mid-scan and mid-CONV -> immediately busy=0, done=0, bcd=000, an=001, seg=1111110; the FSM accepts load on the first edge after release.
- bin=127, load for one cycle -> busy high for 7 cycles; done pulses once as busy falls; bcd=12'h127. Scan with SCAN_DIV=4:
  - an=001 seg=1110000 for 4 cycles
  - an=010 seg=1101101 for 4 cycles
  - an=100 seg=0110000 for 4 cycles, then repeat.
- bin=7, BLANK_LEADING=1 -> bcd=007; hundreds and tens seg=0000000 with an=100/010 still asserted; ones seg=1110000. With BLANK_LEADING=0, all three digits show 1111110, 1111110, 1110000.
- Load 105, then load 42 held during busy -> the second load is ignored; bcd=105 and done pulses once. Reassert 42 in the done cycle -> accepted; bcd=042 seven cycles later.
- Exhaustive sweep 0..127 with one load per value -> bcd digits equal n/100, (n/10)%10 and n%10. Across one full scan cycle, each digit's seg matches the pattern table with blanking applied. Zero mismatches.
- Back-to-back loads every 8 cycles (load during done) -> each accepted, no lost done pulses, scan never stalls or skips an index.
